// File: rtl/isqrt_iter_fsm.sv
`default_nettype none
// ============================================================================
// Module   : isqrt_iter_fsm
// Brief    : Iterative floor(sqrt(x)) responder for a 32-bit operand, one
//            root bit per cycle, with a small request FIFO for busy periods.
//            Optional macro ISQRT_ITER_REM_OUT_EN adds remainder output r.
// Revision : 1.0 - initial release
// ============================================================================
module isqrt_iter_fsm #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        x_vld,
    input  logic [31:0] x,
    output logic        y_vld,
    output logic [15:0] y,
    output logic        overflow
`ifdef ISQRT_ITER_REM_OUT_EN
    ,
    output logic [16:0] r
`endif
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = 1;
    localparam logic [c_PTR_W:0]   c_CNT_ONE = 1;
    localparam logic [c_PTR_W:0]   c_CNT_FULL = FIFO_DEPTH;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [31:0]        r_op;
    logic [17:0]        r_rem;
    logic [15:0]        r_root;
    logic [3:0]         r_iter;
    logic               r_y_vld;
    logic [15:0]        r_y;
    logic               r_overflow;
    logic [31:0]        r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;

    logic [17:0] w_rem_sh;
    logic [17:0] w_trial;
    logic        w_ge;
    logic [17:0] w_rem_nxt;
    logic [15:0] w_root_nxt;
    logic        w_fifo_empty;
    logic        w_fifo_full;
    logic        w_pop;
    logic        w_push_req;
    logic        w_push;
    logic        w_drop;
    logic        w_unused;

    // One restoring digit step: bring down two operand bits, try (root<<2)|1.
    assign w_rem_sh   = {r_rem[15:0], r_op[31:30]};
    assign w_trial    = {r_root, 2'b01};
    assign w_ge       = (w_rem_sh >= w_trial);
    assign w_rem_nxt  = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
    assign w_root_nxt = {r_root[14:0], w_ge};
    // The remainder never exceeds 2*root, so its top bits are shifted out unused.
    assign w_unused   = &{1'b0, r_rem[17:16]};

    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_full  = (r_count == c_CNT_FULL);
    assign w_pop        = (r_state == c_ST_DONE) && !w_fifo_empty;
    assign w_push_req   = x_vld && ((r_state == c_ST_CALC) ||
                                    ((r_state == c_ST_DONE) && !w_fifo_empty));
    assign w_push       = w_push_req && (!w_fifo_full || w_pop);
    assign w_drop       = w_push_req && w_fifo_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wr_ptr] <= x;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_op       <= '0;
            r_rem      <= '0;
            r_root     <= '0;
            r_iter     <= '0;
            r_y_vld    <= 1'b0;
            r_y        <= '0;
            r_overflow <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_y_vld <= 1'b0;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_ONE;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (x_vld) begin
                        r_op    <= x;
                        r_rem   <= '0;
                        r_root  <= '0;
                        r_iter  <= '0;
                        r_state <= c_ST_CALC;
                    end
                end
                c_ST_CALC: begin
                    r_op   <= {r_op[29:0], 2'b00};
                    r_rem  <= w_rem_nxt;
                    r_root <= w_root_nxt;
                    r_iter <= r_iter + 4'd1;
                    if (r_iter == 4'd15) begin
                        r_state <= c_ST_DONE;
                        r_y_vld <= 1'b1;
                        r_y     <= w_root_nxt;
                    end
                end
                c_ST_DONE: begin
                    // Queued requests take priority so results stay in order.
                    if (!w_fifo_empty) begin
                        r_op    <= r_mem[r_rd_ptr];
                        r_rem   <= '0;
                        r_root  <= '0;
                        r_iter  <= '0;
                        r_state <= c_ST_CALC;
                    end else if (x_vld) begin
                        r_op    <= x;
                        r_rem   <= '0;
                        r_root  <= '0;
                        r_iter  <= '0;
                        r_state <= c_ST_CALC;
                    end else begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

`ifdef ISQRT_ITER_REM_OUT_EN
    logic [16:0] r_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_r <= '0;
        end else if ((r_state == c_ST_CALC) && (r_iter == 4'd15)) begin
            r_r <= w_rem_nxt[16:0];
        end
    end

    assign r = r_r;
`endif

    assign y_vld    = r_y_vld;
    assign y        = r_y;
    assign overflow = r_overflow;

endmodule
`default_nettype wire
